// File: rtl/icache_prefetcher_pkg.sv
// Shared bus command encoding plus prefetcher sizing and state encoding.
package icache_prefetcher_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  localparam int PREF_DEPTH      = 4;
  localparam int MAX_OUTSTANDING = 4;
  localparam int LINE_BYTES      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'h0,
    ISSUE     = 2'h1,
    WAIT_SLOT = 2'h2
  } PREF_STATE;

endpackage

// File: rtl/icache_prefetcher_tag_table.sv
// Tracks in-flight prefetch memory tags (1..15) and the line address each one will fill.
// Lookup is combinational; a same-cycle free and allocate of one tag leaves it valid.
module pref_tag_table (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_alloc_en,
  input  logic [3:0]  i_alloc_tag,
  input  logic [63:0] i_alloc_addr,
  input  logic [3:0]  i_lookup_tag,
  output logic        o_lookup_hit,
  output logic [63:0] o_lookup_addr,
  output logic [3:0]  o_count
);

  logic [15:0] r_valid;
  logic [63:0] r_addr [16];
  logic [3:0]  r_count;
  logic [15:0] w_next_valid;
  logic [3:0]  w_next_count;
  logic        w_hit;

  assign w_hit         = (i_lookup_tag != 4'd0) && r_valid[i_lookup_tag];
  assign o_lookup_hit  = w_hit;
  assign o_lookup_addr = w_hit ? r_addr[i_lookup_tag] : 64'd0;
  assign o_count       = r_count;

  // Free before allocate so a returning tag can be reissued by memory in the same cycle.
  always_comb begin
    w_next_valid = r_valid;
    if (w_hit) w_next_valid[i_lookup_tag] = 1'b0;
    if (i_alloc_en && (i_alloc_tag != 4'd0)) w_next_valid[i_alloc_tag] = 1'b1;
    w_next_valid[0] = 1'b0;
    w_next_count = 4'd0;
    for (int i = 1; i < 16; i++) begin
      w_next_count = w_next_count + 4'(w_next_valid[i]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_valid <= 16'd0;
      r_count <= 4'd0;
    end else begin
      r_valid <= w_next_valid;
      r_count <= w_next_count;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_alloc_en && (i_alloc_tag != 4'd0)) r_addr[i_alloc_tag] <= i_alloc_addr;
  end

endmodule

// File: rtl/icache_prefetcher.sv
// Next-line instruction prefetcher: streams sequential lines after a demand miss
// and tags returning memory data with its line address for fill.
module icache_prefetcher #(
  parameter int PREF_DEPTH      = icache_prefetcher_pkg::PREF_DEPTH,
  parameter int MAX_OUTSTANDING = icache_prefetcher_pkg::MAX_OUTSTANDING,
  parameter int LINE_BYTES      = icache_prefetcher_pkg::LINE_BYTES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [63:0]                       proc2Icache_addr,
  input  icache_prefetcher_pkg::BUS_COMMAND proc2Icache_command,
  input  logic                              cachemem_is_miss,
  input  logic                              cachemem_is_miss_pref,
  input  logic                              cachemem_is_full,
  input  logic [3:0]                        Imem2proc_response,
  input  logic [3:0]                        Imem2proc_tag,
  input  logic                              squash,
  output logic [63:0]                       pref2Icache_addr,
  output icache_prefetcher_pkg::BUS_COMMAND pref2Icache_command,
  output logic                              pref_fill_valid,
  output logic [63:0]                       pref_fill_addr,
  output logic [3:0]                        pref_outstanding,
  output logic                              pref_busy
);

  localparam logic [63:0] LINE_INC  = 64'(LINE_BYTES);
  localparam logic [63:0] LINE_MASK = ~(LINE_INC - 64'd1);
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [3:0]  DEPTH_CNT = 4'(PREF_DEPTH);

  icache_prefetcher_pkg::PREF_STATE  r_state, w_state_nxt;
  icache_prefetcher_pkg::BUS_COMMAND w_cmd;
  logic [63:0] r_next_addr, w_addr_nxt;
  logic [63:0] r_trig_line, w_trig_nxt;
  logic [3:0]  r_remaining, w_rem_nxt;
  logic [63:0] w_issue_addr;
  logic [63:0] w_dem_line, w_dem_next;
  logic        w_dem_miss, w_restart, w_accept;
  logic [3:0]  w_count;

  assign w_dem_line = proc2Icache_addr & LINE_MASK;
  assign w_dem_next = w_dem_line + LINE_INC;
  assign w_dem_miss = (proc2Icache_command == icache_prefetcher_pkg::BUS_LOAD) && cachemem_is_miss;
  // A repeat miss on the line that started the current stream must not restart it.
  assign w_restart  = w_dem_miss &&
                      ((r_state == icache_prefetcher_pkg::IDLE) || (w_dem_line != r_trig_line));

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_next_addr;
    w_trig_nxt   = r_trig_line;
    w_rem_nxt    = r_remaining;
    w_cmd        = icache_prefetcher_pkg::BUS_NONE;
    w_issue_addr = 64'd0;
    w_accept     = 1'b0;
    case (r_state)
      icache_prefetcher_pkg::ISSUE: begin
        if (w_count == MAX_CNT) begin
          w_state_nxt = icache_prefetcher_pkg::WAIT_SLOT;
        end else begin
          w_cmd        = icache_prefetcher_pkg::BUS_LOAD;
          w_issue_addr = r_next_addr;
          w_accept     = cachemem_is_miss_pref && !cachemem_is_full && (Imem2proc_response != 4'd0);
          if (!cachemem_is_miss_pref || w_accept) begin
            w_addr_nxt = r_next_addr + LINE_INC;
            w_rem_nxt  = r_remaining - 4'd1;
            if ((w_rem_nxt == 4'd0) || (w_addr_nxt == 64'd0)) w_state_nxt = icache_prefetcher_pkg::IDLE;
          end
        end
      end
      icache_prefetcher_pkg::WAIT_SLOT: begin
        if (w_count < MAX_CNT) w_state_nxt = icache_prefetcher_pkg::ISSUE;
      end
      default: ;
    endcase
    if (w_restart) begin
      w_trig_nxt  = w_dem_line;
      w_addr_nxt  = w_dem_next;
      w_rem_nxt   = DEPTH_CNT;
      w_state_nxt = (w_dem_next == 64'd0) ? icache_prefetcher_pkg::IDLE : icache_prefetcher_pkg::ISSUE;
    end
    if (squash) w_state_nxt = icache_prefetcher_pkg::IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= icache_prefetcher_pkg::IDLE;
      r_next_addr <= 64'd0;
      r_trig_line <= 64'd0;
      r_remaining <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_addr <= w_addr_nxt;
      r_trig_line <= w_trig_nxt;
      r_remaining <= w_rem_nxt;
    end
  end

  pref_tag_table u_tag_table (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_alloc_en    (w_accept),
    .i_alloc_tag   (Imem2proc_response),
    .i_alloc_addr  (r_next_addr),
    .i_lookup_tag  (Imem2proc_tag),
    .o_lookup_hit  (pref_fill_valid),
    .o_lookup_addr (pref_fill_addr),
    .o_count       (w_count)
  );

  assign pref2Icache_addr    = w_issue_addr;
  assign pref2Icache_command = w_cmd;
  assign pref_outstanding    = w_count;
  assign pref_busy           = (r_state != icache_prefetcher_pkg::IDLE);

endmodule

// File: tb/tb_icache_prefetcher.sv
// Directed bench: default instance (depth 4, 4 outstanding) plus a 2-outstanding instance for slot stalls.
module tb_icache_prefetcher;
  import icache_prefetcher_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] dem_addr = 64'd0;
  BUS_COMMAND  dem_cmd = BUS_NONE;
  logic        miss = 1'b0, miss_pref = 1'b1, full = 1'b0, squash = 1'b0;
  logic [3:0]  resp = 4'd0, tag = 4'd0;

  logic [63:0] a_addr, b_addr, a_faddr, b_faddr;
  BUS_COMMAND  a_cmd, b_cmd;
  logic        a_fvld, b_fvld, a_busy, b_busy;
  logic [3:0]  a_out, b_out;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  icache_prefetcher u_dut (
    .clock(clock), .reset(reset), .proc2Icache_addr(dem_addr), .proc2Icache_command(dem_cmd),
    .cachemem_is_miss(miss), .cachemem_is_miss_pref(miss_pref), .cachemem_is_full(full),
    .Imem2proc_response(resp), .Imem2proc_tag(tag), .squash(squash),
    .pref2Icache_addr(a_addr), .pref2Icache_command(a_cmd), .pref_fill_valid(a_fvld),
    .pref_fill_addr(a_faddr), .pref_outstanding(a_out), .pref_busy(a_busy)
  );

  icache_prefetcher #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clock(clock), .reset(reset), .proc2Icache_addr(dem_addr), .proc2Icache_command(dem_cmd),
    .cachemem_is_miss(miss), .cachemem_is_miss_pref(miss_pref), .cachemem_is_full(full),
    .Imem2proc_response(resp), .Imem2proc_tag(tag), .squash(squash),
    .pref2Icache_addr(b_addr), .pref2Icache_command(b_cmd), .pref_fill_valid(b_fvld),
    .pref_fill_addr(b_faddr), .pref_outstanding(b_out), .pref_busy(b_busy)
  );

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    dem_cmd = BUS_NONE; dem_addr = 64'd0; miss = 1'b0; miss_pref = 1'b1;
    full = 1'b0; resp = 4'd0; tag = 4'd0; squash = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic trigger(input logic [63:0] addr);
    dem_cmd = BUS_LOAD; dem_addr = addr; miss = 1'b1;
    step();
    quiet();
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0;
    step(); step();
    #4;
    total++;
    if (a_cmd !== BUS_NONE || a_addr !== 64'd0 || a_out !== 4'd0 || a_fvld !== 1'b0 ||
        a_faddr !== 64'd0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: cmd=%0d addr=%h out=%0d fvld=%b faddr=%h busy=%b expected 0/0/0/0/0/0",
               a_cmd, a_addr, a_out, a_fvld, a_faddr, a_busy);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    dem_cmd = BUS_LOAD; dem_addr = 64'h1004; miss = 1'b1;
    #4;
    total++;
    if (a_busy !== 1'b0 || a_cmd !== BUS_NONE) begin
      bad++; $display("FAIL stream_idle: busy=%b cmd=%0d expected 0/BUS_NONE", a_busy, a_cmd);
    end
    step();
    quiet();
    for (int i = 0; i < 4; i++) begin
      resp = 4'(i + 1);
      #4;
      total++;
      if (a_cmd !== BUS_LOAD || a_addr !== 64'h1008 + 64'(8 * i) || a_out !== 4'(i)) begin
        bad++;
        $display("FAIL stream_issue%0d: cmd=%0d addr=%h out=%0d expected BUS_LOAD %h %0d",
                 i, a_cmd, a_addr, a_out, 64'h1008 + 64'(8 * i), i);
      end
      step();
    end
    resp = 4'd0;
    #4;
    total++;
    if (a_busy !== 1'b0 || a_cmd !== BUS_NONE || a_out !== 4'd4) begin
      bad++; $display("FAIL stream_end: busy=%b cmd=%0d out=%0d expected 0/BUS_NONE/4", a_busy, a_cmd, a_out);
    end
  endtask

  task automatic test_pref_hit();
    logic [3:0] resps [4];
    logic [3:0] outs [4];
    resps = '{4'd1, 4'd0, 4'd2, 4'd3};
    outs  = '{4'd0, 4'd1, 4'd1, 4'd2};
    do_reset();
    trigger(64'h1004);
    for (int i = 0; i < 4; i++) begin
      miss_pref = (i != 1);
      resp = resps[i];
      #4;
      total++;
      if (a_cmd !== BUS_LOAD || a_addr !== 64'h1008 + 64'(8 * i) || a_out !== outs[i]) begin
        bad++;
        $display("FAIL hit_issue%0d: cmd=%0d addr=%h out=%0d expected BUS_LOAD %h %0d",
                 i, a_cmd, a_addr, a_out, 64'h1008 + 64'(8 * i), outs[i]);
      end
      step();
    end
    quiet();
    #4;
    total++;
    if (a_busy !== 1'b0 || a_out !== 4'd3) begin
      bad++; $display("FAIL hit_end: busy=%b out=%0d expected 0/3", a_busy, a_out);
    end
  endtask

  task automatic test_wait_slot();
    do_reset();
    trigger(64'h1004);
    resp = 4'd1; step();
    resp = 4'd2; step();
    resp = 4'd0;
    #4;
    total++;
    if (b_cmd !== BUS_NONE || b_busy !== 1'b1 || b_out !== 4'd2) begin
      bad++; $display("FAIL slot_full: cmd=%0d busy=%b out=%0d expected BUS_NONE/1/2", b_cmd, b_busy, b_out);
    end
    step();
    tag = 4'd5;
    #4;
    total++;
    if (b_cmd !== BUS_NONE || b_busy !== 1'b1 || b_fvld !== 1'b0) begin
      bad++; $display("FAIL slot_wait: cmd=%0d busy=%b fvld=%b expected BUS_NONE/1/0", b_cmd, b_busy, b_fvld);
    end
    step();
    tag = 4'd1;
    #4;
    total++;
    if (b_fvld !== 1'b1 || b_faddr !== 64'h1008 || b_cmd !== BUS_NONE) begin
      bad++; $display("FAIL slot_return: fvld=%b faddr=%h cmd=%0d expected 1/1008/BUS_NONE", b_fvld, b_faddr, b_cmd);
    end
    step();
    tag = 4'd0;
    #4;
    total++;
    if (b_out !== 4'd1 || b_cmd !== BUS_NONE || b_busy !== 1'b1) begin
      bad++; $display("FAIL slot_drain: out=%0d cmd=%0d busy=%b expected 1/BUS_NONE/1", b_out, b_cmd, b_busy);
    end
    step();
    #4;
    total++;
    if (b_cmd !== BUS_LOAD || b_addr !== 64'h1018) begin
      bad++; $display("FAIL slot_resume: cmd=%0d addr=%h expected BUS_LOAD/1018", b_cmd, b_addr);
    end
  endtask

  task automatic test_hold();
    do_reset();
    trigger(64'h1004);
    for (int c = 1; c <= 6; c++) begin
      full = (c == 4 || c == 5);
      resp = (c <= 3) ? 4'd0 : 4'd3;
      #4;
      total++;
      if (a_cmd !== BUS_LOAD || a_addr !== 64'h1008 || a_out !== 4'd0) begin
        bad++; $display("FAIL hold_c%0d: cmd=%0d addr=%h out=%0d expected BUS_LOAD/1008/0", c, a_cmd, a_addr, a_out);
      end
      step();
    end
    quiet();
    tag = 4'd3;
    #4;
    total++;
    if (a_addr !== 64'h1010 || a_out !== 4'd1 || a_fvld !== 1'b1 || a_faddr !== 64'h1008) begin
      bad++;
      $display("FAIL hold_after: addr=%h out=%0d fvld=%b faddr=%h expected 1010/1/1/1008", a_addr, a_out, a_fvld, a_faddr);
    end
  endtask

  task automatic test_squash();
    do_reset();
    trigger(64'h1004);
    resp = 4'd1; step();
    resp = 4'd2; step();
    resp = 4'd0; squash = 1'b1;
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'h1018 || a_out !== 4'd2) begin
      bad++; $display("FAIL squash_cycle: cmd=%0d addr=%h out=%0d expected BUS_LOAD/1018/2", a_cmd, a_addr, a_out);
    end
    step();
    squash = 1'b0; tag = 4'd2;
    #4;
    total++;
    if (a_cmd !== BUS_NONE || a_busy !== 1'b0 || a_fvld !== 1'b1 || a_faddr !== 64'h1010) begin
      bad++;
      $display("FAIL squash_after: cmd=%0d busy=%b fvld=%b faddr=%h expected BUS_NONE/0/1/1010", a_cmd, a_busy, a_fvld, a_faddr);
    end
    step();
    tag = 4'd1; dem_cmd = BUS_LOAD; dem_addr = 64'h2000; miss = 1'b1;
    #4;
    total++;
    if (a_fvld !== 1'b1 || a_faddr !== 64'h1008 || a_out !== 4'd1) begin
      bad++; $display("FAIL squash_fill: fvld=%b faddr=%h out=%0d expected 1/1008/1", a_fvld, a_faddr, a_out);
    end
    step();
    quiet();
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'h2008 || a_out !== 4'd0) begin
      bad++; $display("FAIL squash_retrig: cmd=%0d addr=%h out=%0d expected BUS_LOAD/2008/0", a_cmd, a_addr, a_out);
    end
  endtask

  task automatic test_retarget();
    do_reset();
    trigger(64'h3000);
    dem_cmd = BUS_LOAD; dem_addr = 64'h3004; miss = 1'b1;
    step();
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'h3008) begin
      bad++; $display("FAIL retarget_same: cmd=%0d addr=%h expected BUS_LOAD/3008", a_cmd, a_addr);
    end
    dem_addr = 64'h4000;
    step();
    quiet();
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'h4008) begin
      bad++; $display("FAIL retarget_new: cmd=%0d addr=%h expected BUS_LOAD/4008", a_cmd, a_addr);
    end
    squash = 1'b1; dem_cmd = BUS_LOAD; dem_addr = 64'h5000; miss = 1'b1;
    step();
    quiet();
    #4;
    total++;
    if (a_busy !== 1'b0 || a_cmd !== BUS_NONE) begin
      bad++; $display("FAIL squash_beats_retarget: busy=%b cmd=%0d expected 0/BUS_NONE", a_busy, a_cmd);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    trigger(64'hFFFF_FFFF_FFFF_FFE8);
    resp = 4'd1;
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      bad++; $display("FAIL wrap_first: cmd=%0d addr=%h expected BUS_LOAD/fff0", a_cmd, a_addr);
    end
    step();
    resp = 4'd2;
    #4;
    total++;
    if (a_cmd !== BUS_LOAD || a_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      bad++; $display("FAIL wrap_second: cmd=%0d addr=%h expected BUS_LOAD/fff8", a_cmd, a_addr);
    end
    step();
    resp = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++;
      if (a_cmd !== BUS_NONE || a_busy !== 1'b0 || a_out !== 4'd2) begin
        bad++; $display("FAIL wrap_end%0d: cmd=%0d busy=%b out=%0d expected BUS_NONE/0/2", i, a_cmd, a_busy, a_out);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    trigger(64'h1004);
    resp = 4'd1; step();
    resp = 4'd0; reset = 1'b0; step();
    reset = 1'b1; tag = 4'd1;
    #4;
    total++;
    if (a_fvld !== 1'b0 || a_out !== 4'd0 || a_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid: fvld=%b out=%0d busy=%b expected 0/0/0", a_fvld, a_out, a_busy);
    end
    step();
    quiet();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pref_hit();
    test_wait_slot();
    test_hold();
    test_squash();
    test_retarget();
    test_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
